// File: rtl/seg7_decoder.sv
// seg7_decoder: recovers the 4-digit value shown on a multiplexed, active-low
// 7-segment display by watching its segment, dot and anode lines.
// Optional build macro SEG7_DEC_HEX_EN: also decode A, b, C, d, E, F glyphs.
module seg7_decoder #(
  parameter int unsigned STABLE_CYC  = 16,
  parameter int unsigned TIMEOUT_CYC = 2_000_000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic [6:0]  seg,
  input  logic        dp,
  input  logic [3:0]  an,
  output logic [15:0] x,
  output logic [3:0]  x_dp,
  output logic        valid,
  output logic        err,
  output logic        stale
);

  localparam int unsigned SW = $clog2(STABLE_CYC + 1);
  localparam int unsigned TW = $clog2(TIMEOUT_CYC + 1);
  localparam int unsigned PW = 12;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_HUNT  = 2'd1,
    S_ACCUM = 2'd2
  } state_e;

  // Synchronizer stages
  logic [6:0]    seg_s1_q, seg_s2_q;
  logic          dp_s1_q, dp_s2_q;
  logic [3:0]    an_s1_q, an_s2_q;

  // Capture and frame state
  state_e        state_q, state_d;
  logic [PW-1:0] pat_prev_q, pat_prev_d;
  logic [SW-1:0] stab_q, stab_d;
  logic [3:0]    mask_q, mask_d;
  logic [15:0]   digit_q, digit_d;
  logic [3:0]    dot_q, dot_d;
  logic [3:0]    derr_q, derr_d;
  logic [TW-1:0] tmo_q, tmo_d;

  // Output registers
  logic [15:0]   x_q, x_d;
  logic [3:0]    x_dp_q, x_dp_d;
  logic          valid_q, valid_d;
  logic          err_q, err_d;
  logic          stale_q, stale_d;

  // Combinational helpers
  logic [PW-1:0] pat_c;
  logic          cand_c;
  logic [1:0]    idx_c;
  logic [3:0]    dec_val_c;
  logic          dec_bad_c;
  logic          capture_c;
  logic          commit_c;

  assign pat_c = {an_s2_q, seg_s2_q, dp_s2_q};

  // Candidate only when exactly one anode is driven; idx_c names that digit
  always_comb begin
    cand_c = 1'b1;
    idx_c  = 2'd0;
    case (an_s2_q)
      4'b1110: idx_c = 2'd0;
      4'b1101: idx_c = 2'd1;
      4'b1011: idx_c = 2'd2;
      4'b0111: idx_c = 2'd3;
      default: cand_c = 1'b0;
    endcase
  end

  // Glyph decode; unknown glyphs map to 4'hE and flag an error
  always_comb begin
    dec_val_c = 4'hE;
    dec_bad_c = 1'b0;
    case (seg_s2_q)
      7'b1000000: dec_val_c = 4'h0;
      7'b1111001: dec_val_c = 4'h1;
      7'b0100100: dec_val_c = 4'h2;
      7'b0110000: dec_val_c = 4'h3;
      7'b0011001: dec_val_c = 4'h4;
      7'b0010010: dec_val_c = 4'h5;
      7'b0000010: dec_val_c = 4'h6;
      7'b1111000: dec_val_c = 4'h7;
      7'b0000000: dec_val_c = 4'h8;
      7'b0010000: dec_val_c = 4'h9;
      7'b1111111: dec_val_c = 4'hF;
`ifdef SEG7_DEC_HEX_EN
      7'b0001000: dec_val_c = 4'hA;
      7'b0000011: dec_val_c = 4'hB;
      7'b1000110: dec_val_c = 4'hC;
      7'b0100001: dec_val_c = 4'hD;
      7'b0000110: dec_val_c = 4'hE;
      7'b0001110: dec_val_c = 4'hF;
`endif
      default: begin
        dec_val_c = 4'hE;
        dec_bad_c = 1'b1;
      end
    endcase
  end

  // Next-state: stability counting, digit capture, frame commit, timeout
  always_comb begin
    state_d    = state_q;
    pat_prev_d = pat_c;
    stab_d     = stab_q;
    mask_d     = mask_q;
    digit_d    = digit_q;
    dot_d      = dot_q;
    derr_d     = derr_q;
    tmo_d      = tmo_q;
    x_d        = x_q;
    x_dp_d     = x_dp_q;
    valid_d    = 1'b0;
    err_d      = err_q;
    stale_d    = stale_q;
    capture_c  = 1'b0;
    commit_c   = 1'b0;

    if (!en) begin
      // Disabled: drop any partial frame, hold the published outputs
      state_d = S_IDLE;
      mask_d  = 4'h0;
      derr_d  = 4'h0;
      stab_d  = '0;
    end else begin
      tmo_d = (tmo_q == TW'(TIMEOUT_CYC)) ? tmo_q : TW'(tmo_q + 1'b1);

      if (state_q == S_IDLE) begin
        state_d = S_HUNT;
        stab_d  = '0;
      end else begin
        if (!cand_c)
          stab_d = '0;
        else if (pat_c != pat_prev_q)
          stab_d = SW'(1);
        else if (stab_q < SW'(STABLE_CYC))
          stab_d = SW'(stab_q + 1'b1);

        // Fire once when the count first reaches the threshold
        capture_c = cand_c && (stab_d == SW'(STABLE_CYC)) &&
                    ((stab_q != SW'(STABLE_CYC)) || (pat_c != pat_prev_q));
        commit_c  = (state_q == S_ACCUM) && (mask_q == 4'hF);

        if (commit_c) begin
          x_d     = digit_q;
          x_dp_d  = dot_q;
          err_d   = |derr_q;
          valid_d = 1'b1;
          mask_d  = 4'h0;
          derr_d  = 4'h0;
          tmo_d   = '0;
          state_d = S_HUNT;
        end

        if (capture_c) begin
          digit_d[{idx_c, 2'b00} +: 4] = dec_val_c;
          dot_d[idx_c]                 = ~dp_s2_q;
          derr_d[idx_c]                = dec_bad_c;
          mask_d[idx_c]                = 1'b1;
          state_d                      = S_ACCUM;
        end
      end

      stale_d = (tmo_d == TW'(TIMEOUT_CYC));
    end
  end

  // State, synchronizer and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg_s1_q   <= '0;
      seg_s2_q   <= '0;
      dp_s1_q    <= 1'b0;
      dp_s2_q    <= 1'b0;
      an_s1_q    <= '0;
      an_s2_q    <= '0;
      state_q    <= S_IDLE;
      pat_prev_q <= '0;
      stab_q     <= '0;
      mask_q     <= '0;
      digit_q    <= '0;
      dot_q      <= '0;
      derr_q     <= '0;
      tmo_q      <= '0;
      x_q        <= '0;
      x_dp_q     <= '0;
      valid_q    <= 1'b0;
      err_q      <= 1'b0;
      stale_q    <= 1'b0;
    end else begin
      seg_s1_q   <= seg;
      seg_s2_q   <= seg_s1_q;
      dp_s1_q    <= dp;
      dp_s2_q    <= dp_s1_q;
      an_s1_q    <= an;
      an_s2_q    <= an_s1_q;
      state_q    <= state_d;
      pat_prev_q <= pat_prev_d;
      stab_q     <= stab_d;
      mask_q     <= mask_d;
      digit_q    <= digit_d;
      dot_q      <= dot_d;
      derr_q     <= derr_d;
      tmo_q      <= tmo_d;
      x_q        <= x_d;
      x_dp_q     <= x_dp_d;
      valid_q    <= valid_d;
      err_q      <= err_d;
      stale_q    <= stale_d;
    end
  end

  assign x     = x_q;
  assign x_dp  = x_dp_q;
  assign valid = valid_q;
  assign err   = err_q;
  assign stale = stale_q;

endmodule

// File: tb/tb_seg7_decoder.sv
// Directed bench for seg7_decoder: drives scanned display patterns and
// checks decoded frames, dots, error, stale and reset/enable behaviour.
module tb_seg7_decoder;

  localparam int unsigned TMO = 400;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en;
  logic [6:0]  seg;
  logic        dp;
  logic [3:0]  an;
  logic [15:0] x;
  logic [3:0]  x_dp;
  logic        valid;
  logic        err;
  logic        stale;

  int n_assert = 0;
  int n_fail   = 0;
  int valid_cnt = 0;
  int base_cnt;
  logic prev_valid = 1'b0;
  logic dbl_valid  = 1'b0;

  seg7_decoder #(.STABLE_CYC(16), .TIMEOUT_CYC(TMO)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .seg(seg), .dp(dp), .an(an),
    .x(x), .x_dp(x_dp), .valid(valid), .err(err), .stale(stale)
  );

  always #5 clk = ~clk;

  // Count valid pulses and flag back-to-back pulses
  always @(negedge clk) begin
    if (valid) valid_cnt++;
    if (valid && prev_valid) dbl_valid = 1'b1;
    prev_valid = valid;
  end

  // Active-low glyphs, bit 0 = segment a
  function automatic logic [6:0] enc(input logic [3:0] d);
    case (d)
      4'h0: enc = 7'b1000000;
      4'h1: enc = 7'b1111001;
      4'h2: enc = 7'b0100100;
      4'h3: enc = 7'b0110000;
      4'h4: enc = 7'b0011001;
      4'h5: enc = 7'b0010010;
      4'h6: enc = 7'b0000010;
      4'h7: enc = 7'b1111000;
      4'h8: enc = 7'b0000000;
      4'h9: enc = 7'b0010000;
      4'hA: enc = 7'b0001000;
      default: enc = 7'b1111111;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic blank(input int n);
    an  = 4'b1111;
    seg = 7'b1111111;
    dp  = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  // Scan selected digits from an[3] down to an[0], then blank the display
  task automatic scan(input logic [3:0] which, input logic [15:0] digs,
                      input logic [3:0] dots, input int hold);
    for (int i = 3; i >= 0; i--) begin
      if (which[i]) begin
        an     = 4'b1111;
        an[i]  = 1'b0;
        seg    = enc(digs[i*4 +: 4]);
        dp     = ~dots[i];
        repeat (hold) @(negedge clk);
      end
    end
    blank(10);
  endtask

  initial begin
    rst_n = 1'b0;
    en    = 1'b0;
    an    = 4'b1111;
    seg   = 7'b1111111;
    dp    = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset_x", x, 16'h0000);
    chk("reset_x_dp", 16'(x_dp), 16'h0);
    chk("reset_valid", 16'(valid), 16'h0);
    chk("reset_err", 16'(err), 16'h0);
    chk("reset_stale", 16'(stale), 16'h0);
    rst_n = 1'b1;
    @(negedge clk);
    en = 1'b1;

    // Legal scan 1234
    base_cnt = valid_cnt;
    scan(4'hF, 16'h1234, 4'h0, 20);
    chk("f1234_valid_cnt", 16'(valid_cnt - base_cnt), 16'd1);
    chk("f1234_x", x, 16'h1234);
    chk("f1234_x_dp", 16'(x_dp), 16'h0);
    chk("f1234_err", 16'(err), 16'h0);
    chk("f1234_stale", 16'(stale), 16'h0);

    // Digits too short to capture; stale after the timeout
    base_cnt = valid_cnt;
    scan(4'hF, 16'h5678, 4'h0, 10);
    chk("short_no_valid", 16'(valid_cnt - base_cnt), 16'd0);
    chk("short_stale_early", 16'(stale), 16'h0);
    blank(TMO);
    chk("short_stale_late", 16'(stale), 16'h1);
    chk("short_x_held", x, 16'h1234);
    en = 1'b0;
    blank(20);
    chk("en_low_stale_held", 16'(stale), 16'h1);
    en = 1'b1;

    // Two anodes low is ignored, then a legal 0000 frame
    base_cnt = valid_cnt;
    an  = 4'b0011;
    seg = enc(4'h8);
    dp  = 1'b1;
    repeat (100) @(negedge clk);
    chk("multi_an_no_valid", 16'(valid_cnt - base_cnt), 16'd0);
    scan(4'hF, 16'h0000, 4'h0, 20);
    chk("f0000_valid_cnt", 16'(valid_cnt - base_cnt), 16'd1);
    chk("f0000_x", x, 16'h0000);
    chk("f0000_stale_clr", 16'(stale), 16'h0);

    // Glyph "A" on an[0]
    base_cnt = valid_cnt;
    scan(4'hF, 16'h123A, 4'h0, 20);
    chk("fA_valid_cnt", 16'(valid_cnt - base_cnt), 16'd1);
`ifdef SEG7_DEC_HEX_EN
    chk("fA_x", x, 16'h123A);
    chk("fA_err", 16'(err), 16'h0);
`else
    chk("fA_x", x, 16'h123E);
    chk("fA_err", 16'(err), 16'h1);
`endif

    // Dot on an[2] only
    base_cnt = valid_cnt;
    scan(4'hF, 16'h5678, 4'b0100, 20);
    chk("f5678_valid_cnt", 16'(valid_cnt - base_cnt), 16'd1);
    chk("f5678_x", x, 16'h5678);
    chk("f5678_x_dp", 16'(x_dp), 16'h4);
    chk("f5678_err", 16'(err), 16'h0);

    // Enable drop mid-frame discards the partial digits
    base_cnt = valid_cnt;
    scan(4'b1100, 16'h1200, 4'h0, 20);
    en = 1'b0;
    blank(10);
    chk("en_drop_x_held", x, 16'h5678);
    en = 1'b1;
    scan(4'b0011, 16'h0099, 4'h0, 20);
    chk("en_drop_no_commit", 16'(valid_cnt - base_cnt), 16'd0);
    scan(4'hF, 16'h9999, 4'h0, 20);
    chk("en_drop_valid_cnt", 16'(valid_cnt - base_cnt), 16'd1);
    chk("en_drop_x", x, 16'h9999);

    // Reset mid-frame discards the partial digits and clears outputs
    scan(4'b1100, 16'h1200, 4'h0, 20);
    rst_n = 1'b0;
    @(negedge clk);
    chk("rst_mid_x", x, 16'h0000);
    chk("rst_mid_valid", 16'(valid), 16'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    base_cnt = valid_cnt;
    scan(4'b0011, 16'h0099, 4'h0, 20);
    chk("rst_no_commit", 16'(valid_cnt - base_cnt), 16'd0);
    chk("rst_x_zero", x, 16'h0000);
    scan(4'hF, 16'h9999, 4'h0, 20);
    chk("rst_valid_cnt", 16'(valid_cnt - base_cnt), 16'd1);
    chk("rst_x", x, 16'h9999);

    chk("no_double_valid", 16'(dbl_valid), 16'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/seg7_decoder.md
SEG7_DECODER -- requirements
Module: seg7_decoder

Interface
REQ-001 SHALL have parameter STABLE_CYC, default 16, meaning cycles the (an,seg,dp) pattern must stay unchanged before a digit is captured.
REQ-002 SHALL have parameter TIMEOUT_CYC, default 2_000_000, meaning cycles without a completed frame before stale asserts (20 ms at 100 MHz).
REQ-003 SHALL have ports:
- clk  input  1  clock, 100 MHz; single clock domain.
- rst_n  input  1  asynchronous active-low reset.
- en  input  1  capture enable.
- seg  input  7  segment lines, active low; bit 0 = a through bit 6 = g.
- dp  input  1  dot line, active low.
- an  input  4  anode lines, active low; bit 0 = rightmost digit.
- x  output  16  decoded 4-digit code; x[3:0] = an[0] digit.
- x_dp  output  4  decoded dots.
- valid  output  1  one-cycle pulse when x/x_dp update.
- err  output  1  last frame contained an undecodable pattern.
- stale  output  1  no frame completed within TIMEOUT_CYC.

Function
REQ-004 SHALL pass seg, dp and an through a 2-flop synchronizer before any use; latency is counted from synchronized values.
REQ-005 SHALL run FSM IDLE/HUNT/ACCUM: IDLE while en=0; en=1 -> HUNT; first digit captured -> ACCUM; all 4 digits captured -> frame commit, back to HUNT.
REQ-006 SHALL treat the pattern as a candidate only when exactly one an bit is low; an=4'b1111 (blank or dim gap) or more than one low bit SHALL reset the stability counter and capture nothing.
REQ-007 SHALL count consecutive cycles of an unchanged candidate pattern; on the cycle the count reaches STABLE_CYC, SHALL capture that digit once and not recapture until the pattern changes.
REQ-008 SHALL decode each captured digit as follows:
- 7'b1000000 -> 0, 7'b1111001 -> 1, plus standard 2..9 -> 2..9.
- 7'b1111111 (blank) -> 4'hF.
- Any other pattern -> 4'hE with the frame error flag set.
REQ-009 SHALL record dot = ~dp per captured digit.
REQ-010 SHALL keep a 4-bit captured mask; recapturing an already captured digit overwrites its value.
REQ-011 SHALL commit when the mask becomes 4'hF: on the next cycle, load x, x_dp and err, pulse valid for 1 cycle, clear the mask and the frame error flag, and clear the timeout counter and stale.
REQ-012 SHALL increment a timeout counter every cycle en=1, saturating at TIMEOUT_CYC; stale=1 while the counter equals TIMEOUT_CYC.
REQ-013 SHALL hold x, x_dp, err and stale while en=0; en falling SHALL clear the mask and stability counter and enter IDLE, with no partial commit.
REQ-014 SHALL never pulse valid on two consecutive cycles.

Reset
REQ-015 SHALL, while rst_n=0, immediately force x=16'h0000, x_dp=0, valid=0, err=0, stale=0, state IDLE, and clear mask, counters and synchronizers.
REQ-016 SHALL resume from IDLE on the first clk edge after rst_n rises; a frame in progress is discarded.

Configuration
REQ-017 SHALL, with macro SEG7_DEC_HEX_EN defined, additionally decode A, b, C, d, E, F patterns to 4'hA..4'hF without setting err; blank still decodes to 4'hF.
REQ-018 SHALL, with SEG7_DEC_HEX_EN undefined, treat those patterns as undecodable per REQ-008.

Verification
REQ-019 Scan digits "1","2","3","4" (an[3]..an[0]), 20 cycles each, dp high, en=1 -> a valid pulse follows, with x=16'h1234, x_dp=0, err=0.
REQ-020 Same scan with each digit held 10 cycles (< STABLE_CYC) -> no valid; stale=1 after TIMEOUT_CYC cycles.
REQ-021 an=4'b0011 for 100 cycles, then a legal scan of "0000" -> the bad interval is ignored; x=16'h0000, single valid.
REQ-022 Digit an[0] shows 7'b0001000 ("A") -> without the macro, x[3:0]=4'hE and err=1; with SEG7_DEC_HEX_EN, x[3:0]=4'hA and err=0.
REQ-023 dp low on an[2] only; scan "5678" -> x=16'h5678, x_dp=4'b0100.
REQ-024 Drop en or assert rst_n=0 after 2 digits, then re-enable and scan "9999" -> no commit of the partial frame; x=16'h9999 after one valid (x=0 beforehand in the reset case).
